// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcode encoding, FSM states, opcode width.
package alu_pkg;
    localparam int OPW = 4;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 4'b1101,
        OP_AND  = 4'b1001,
        OP_MUL  = 4'b0101,
        OP_NOT  = 4'b0001,
        OP_NAND = 4'b1100,
        OP_SUB  = 4'b0010,
        OP_XNOR = 4'b0011,
        OP_NOR  = 4'b0110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FULL
    } alu_state_e;
endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned WIDTH x WIDTH shift-add multiplier. Bit 0 is folded in on the start
// edge so the product is ready WIDTH-1 edges later and done is high in that cycle.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d;

    assign done    = run_q && (cnt_q == CW'(WIDTH));
    assign product = acc_q;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start) begin
            acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_d = b >> 1;
            cnt_d    = CW'(1);
            run_d    = 1'b1;
        end else if (run_q) begin
            if (done) begin
                run_d = 1'b0;
            end else begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops plus an iterative multiply, with one registered
// result slot between the operand source and the result sink.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [OPW+2*WIDTH-1:0]   in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out,
    output logic                     sign,
    output logic                     carr,
    output logic                     zero,
    output logic                     out_valid,
    input  logic                     out_ready
);
    logic [OPW-1:0]     op;
    logic [WIDTH-1:0]   a, b;
    logic               is_mul, accept;
    logic               mul_start, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   res;
    logic               res_s, res_c;

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               sign_q, sign_d, carr_q, carr_d, zero_q, zero_d;

    assign op = in[OPW+2*WIDTH-1 -: OPW];
    assign b  = in[2*WIDTH-1 -: WIDTH];
    assign a  = in[WIDTH-1:0];

    assign is_mul    = (op == OP_MUL);
    // Ready depends only on state and the sink, never on in_valid.
    assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == FULL) && out_ready));
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && is_mul;

    assign out_valid = (state_q == FULL);
    assign out       = out_q;
    assign sign      = sign_q;
    assign carr      = carr_q;
    assign zero      = zero_q;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    always_comb begin
        res   = '0;
        res_s = 1'b0;
        res_c = 1'b0;
        sum   = {1'b0, a} + {1'b0, b};
        case (op)
            OP_ADD:  begin res = sum[WIDTH-1:0]; res_c = sum[WIDTH]; end
            OP_AND:  res = a & b;
            OP_NOT:  res = ~a;
            OP_NAND: res = ~(a & b);
            OP_SUB:  begin
                if (b > a) begin
                    res   = b - a;
                    res_s = 1'b1;
                end else begin
                    res = a - b;
                end
            end
            OP_XNOR: res = ~(a ^ b);
            OP_NOR:  res = ~(a | b);
            default: res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sign_d  = sign_q;
        carr_d  = carr_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE:    if (accept) state_d = is_mul ? BUSY : FULL;
            BUSY:    if (mul_done) state_d = FULL;
            FULL:    if (out_ready) state_d = accept ? (is_mul ? BUSY : FULL) : IDLE;
            default: state_d = IDLE;
        endcase
        // zero is only recomputed when a new result is loaded.
        if (accept && !is_mul) begin
            out_d  = res;
            sign_d = res_s;
            carr_d = res_c;
            zero_d = (res == '0) && !res_c;
        end else if ((state_q == BUSY) && mul_done) begin
            out_d  = mul_prod[WIDTH-1:0];
            sign_d = 1'b0;
            carr_d = |mul_prod[2*WIDTH-1:WIDTH];
            zero_d = (mul_prod[WIDTH-1:0] == '0) && !(|mul_prod[2*WIDTH-1:WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            sign_q  <= 1'b0;
            carr_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sign_q  <= sign_d;
            carr_q  <= carr_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=4) with a result scoreboard.
module tb_alu_pipe;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [4+2*W-1:0] in_w = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     out_w;
    logic             sign, carr, zero, out_valid;
    logic             out_ready = 1'b1;

    typedef struct packed {
        logic [W-1:0] o;
        logic         s;
        logic         c;
        logic         z;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_w),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out_w),
        .sign      (sign),
        .carr      (carr),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        int unsigned p;
        r = '0;
        p = 0;
        case (op)
            4'b1101: begin p = a + b; r.o = W'(p); r.c = (p >> W) != 0; end
            4'b1001: r.o = a & b;
            4'b0101: begin p = a * b; r.o = W'(p); r.c = (p >> W) != 0; end
            4'b0001: r.o = ~a;
            4'b1100: r.o = ~(a & b);
            4'b0010: begin
                if (b > a) begin r.o = b - a; r.s = 1'b1; end
                else r.o = a - b;
            end
            4'b0011: r.o = ~(a ^ b);
            4'b0110: r.o = ~(a | b);
            default: r.o = '0;
        endcase
        r.z = (r.o == '0) && !r.c;
        return r;
    endfunction

    // Scoreboard: compare every handshaked result in order.
    always @(negedge clk) begin
        res_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_out",  out_w, e.o);
                chk("sb_sign", sign,  e.s);
                chk("sb_carr", carr,  e.c);
                chk("sb_zero", zero,  e.z);
            end
        end
    end

    // Present a request and hold it until accepted; returns 1 after the accept edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok;
        int n;
        n = 0;
        in_w = {op, b, a};
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 50);
        if (!ok) chk("accept_timeout", ok, 1);
        else exp_q.push_back(model(op, a, b));
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        #1;
    endtask

    initial begin
        int t0;
        int n;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_in_ready", in_ready, 1);
        chk("idle_outputs", {out_w, sign, carr, zero}, 0);
        @(posedge clk); #1;

        send(4'b1101, 4'd9, 4'd8);
        in_valid = 1'b0;
        chk("add_latency", out_valid, 1);
        chk("add_out", out_w, 1);
        chk("add_carr", carr, 1);
        chk("add_zero", zero, 0);
        send(4'b1101, 4'd0, 4'd0);
        in_valid = 1'b0;
        chk("add0_zero", zero, 1);

        t0 = int'($time);
        send(4'b0010, 4'd3, 4'd5);
        chk("sub35_out", out_w, 2);
        chk("sub35_sign", sign, 1);
        send(4'b0010, 4'd5, 4'd3);
        chk("sub53_sign", sign, 0);
        send(4'b0010, 4'd4, 4'd4);
        in_valid = 1'b0;
        chk("sub_throughput", int'($time) - t0, 30);
        chk("sub44_zero", zero, 1);

        send(4'b0101, 4'd7, 4'd3);
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            chk("mul_busy_in_ready", in_ready, 0);
            chk("mul_busy_out_valid", out_valid, 0);
        end
        @(negedge clk);
        chk("mul_latency", out_valid, 1);
        chk("mul73_out", out_w, 5);
        chk("mul73_carr", carr, 1);
        @(posedge clk); #1;

        send(4'b0101, 4'd3, 4'd2);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mul32_done", out_valid, 1);
        chk("mul32_out", out_w, 6);
        chk("mul32_carr", carr, 0);
        wait_drain();

        out_ready = 1'b0;
        send(4'b0110, 4'd5, 4'd3);
        in_w = {4'b0011, 4'd6, 4'd6};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_hold", out_w, 4'h8);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'b0011, 4'd6, 4'd6);
        chk("bp_xnor_out", out_w, 4'hF);
        send(4'b1100, 4'hF, 4'h3);
        in_valid = 1'b0;
        wait_drain();

        send(4'b0101, 4'd7, 4'd3);
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_no_out", out_valid, 0);
        end
        @(posedge clk); #1;
        send(4'b1101, 4'd2, 4'd3);
        in_valid = 1'b0;
        chk("post_rst_add_valid", out_valid, 1);
        chk("post_rst_add_out", out_w, 5);
        send(4'b0000, 4'd7, 4'd9);
        in_valid = 1'b0;
        chk("op0_out", out_w, 0);
        chk("op0_zero", zero, 1);
        chk("op0_sign", sign, 0);
        chk("op0_carr", carr, 0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
